// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and helpers for the register file with busy scoreboard.
// Imported by the interface, the read port and the top.
package regfile_pkg;

  localparam int REGFILE_DATA_W    = 16;
  localparam int REGFILE_ADDR_W    = 2;
  localparam int REGFILE_MAX_DEPTH = 64;

  function automatic int unsigned busy_popcount(
    input logic [REGFILE_MAX_DEPTH-1:0] v
  );
    int unsigned n;
    n = 0;
    for (int i = 0; i < REGFILE_MAX_DEPTH; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bus between the issue logic and the register file scoreboard.
// Master drives addresses and write/reserve requests; slave returns reads.
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int ADDR_W = REGFILE_ADDR_W
);

  logic [ADDR_W-1:0] R1;
  logic [ADDR_W-1:0] R2;
  logic [ADDR_W-1:0] Rd;
  logic              RegWrite;
  logic [DATA_W-1:0] WriteData;
  logic              Reserve;
  logic [ADDR_W-1:0] ReserveAddr;
  logic [DATA_W-1:0] OutputA;
  logic [DATA_W-1:0] OutputB;
  logic              BusyA;
  logic              BusyB;
  logic [ADDR_W:0]   PendingCount;

  modport master (
    output R1, R2, Rd, RegWrite, WriteData,
    output Reserve, ReserveAddr,
    input  OutputA, OutputB, BusyA, BusyB,
    input  PendingCount
  );

  modport slave (
    input  R1, R2, Rd, RegWrite, WriteData,
    input  Reserve, ReserveAddr,
    output OutputA, OutputB, BusyA, BusyB,
    output PendingCount
  );

endinterface

// File: rtl/regfile_scoreboard_read_port.sv
// One combinational read port: address mux, writeback bypass and
// same-cycle busy clear on writeback.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int          DATA_W   = REGFILE_DATA_W,
  parameter int          ADDR_W   = REGFILE_ADDR_W,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic [ADDR_W-1:0]                    addr_i,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]   regs_i,
  input  logic [(1<<ADDR_W)-1:0]               busy_i,
  input  logic                                 wr_en_i,
  input  logic [ADDR_W-1:0]                    wr_addr_i,
  input  logic [DATA_W-1:0]                    wr_data_i,
  output logic [DATA_W-1:0]                    data_o,
  output logic                                 busy_o
);

  localparam bit ZERO_HW = (ZERO_REG != 0);

  logic hit;
  logic zero_rd;

  // wr_en_i is already gated by reset and by the hardwired zero register
  assign hit     = wr_en_i && (wr_addr_i == addr_i);
  assign zero_rd = ZERO_HW && (addr_i == '0);

  always_comb begin
    data_o = regs_i[addr_i];
    if (zero_rd) data_o = '0;
    if (hit)     data_o = wr_data_i;
  end

  assign busy_o = busy_i[addr_i] && !hit;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with a per-register busy scoreboard and pending count.
// Reserve marks an outstanding write; RegWrite writes back and clears it.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int          DATA_W   = REGFILE_DATA_W,
  parameter int          ADDR_W   = REGFILE_ADDR_W,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic                 CLK,
  input  logic                 Reset,
  regfile_scoreboard_if.slave  bus
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam bit ZERO_HW = (ZERO_REG != 0);

  logic [DEPTH-1:0][DATA_W-1:0] regs_q;
  logic [DEPTH-1:0][DATA_W-1:0] regs_d;
  logic [DEPTH-1:0]             busy_q;
  logic [DEPTH-1:0]             busy_d;
  logic [ADDR_W:0]              count_q;
  logic [ADDR_W:0]              count_d;

  logic wr_en;
  logic rsv_en;

  assign wr_en  = bus.RegWrite && !Reset &&
                  !(ZERO_HW && (bus.Rd == '0));
  assign rsv_en = bus.Reserve && !Reset &&
                  !(ZERO_HW && (bus.ReserveAddr == '0));

  // Reserve is applied last so it wins over a same-address writeback
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_en) begin
      regs_d[bus.Rd] = bus.WriteData;
      busy_d[bus.Rd] = 1'b0;
    end
    if (rsv_en) begin
      busy_d[bus.ReserveAddr] = 1'b1;
    end
    count_d = (ADDR_W+1)'(
      busy_popcount(REGFILE_MAX_DEPTH'(busy_d)));
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      regs_q  <= '0;
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_port_a (
    .addr_i    (bus.R1),
    .regs_i    (regs_q),
    .busy_i    (busy_q),
    .wr_en_i   (wr_en),
    .wr_addr_i (bus.Rd),
    .wr_data_i (bus.WriteData),
    .data_o    (bus.OutputA),
    .busy_o    (bus.BusyA)
  );

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_port_b (
    .addr_i    (bus.R2),
    .regs_i    (regs_q),
    .busy_i    (busy_q),
    .wr_en_i   (wr_en),
    .wr_addr_i (bus.Rd),
    .wr_data_i (bus.WriteData),
    .data_o    (bus.OutputB),
    .busy_o    (bus.BusyB)
  );

  assign bus.PendingCount = count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, zero-register
// sequence and randomized cycles against an array-based reference model.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic [1:0]  r1, r2, rd, ra;
  logic        we, rsv;
  logic [15:0] wd;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(2)) bus0 ();
  regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(2)) bus1 ();

  assign bus0.R1 = r1;
  assign bus0.R2 = r2;
  assign bus0.Rd = rd;
  assign bus0.RegWrite = we;
  assign bus0.WriteData = wd;
  assign bus0.Reserve = rsv;
  assign bus0.ReserveAddr = ra;
  assign bus1.R1 = r1;
  assign bus1.R2 = r2;
  assign bus1.Rd = rd;
  assign bus1.RegWrite = we;
  assign bus1.WriteData = wd;
  assign bus1.Reserve = rsv;
  assign bus1.ReserveAddr = ra;

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(0)) u0 (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus0)
  );

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(1)) u1 (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  r1, r2, rd;
    logic        we;
    logic [15:0] wd;
    logic        rsv;
    logic [1:0]  ra;
    logic [15:0] ea, eb;
    logic        eba, ebb;
    logic [2:0]  epc;
  } vec_t;

  vec_t tv[16];

  // reference model: plain arrays indexed by [zero_reg][address]
  logic [15:0] mem [2][4];
  bit          bsy [2][4];

  function automatic vec_t mk(
    logic rs, logic [1:0] a1, logic [1:0] a2, logic [1:0] d,
    logic w, logic [15:0] data, logic rv, logic [1:0] rva,
    logic [15:0] xa, logic [15:0] xb, logic xba, logic xbb,
    logic [2:0] xpc
  );
    vec_t v;
    v.rst = rs; v.r1 = a1; v.r2 = a2; v.rd = d;
    v.we = w; v.wd = data; v.rsv = rv; v.ra = rva;
    v.ea = xa; v.eb = xb; v.eba = xba; v.ebb = xbb;
    v.epc = xpc;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(
    logic rs, logic [1:0] a1, logic [1:0] a2, logic [1:0] d,
    logic w, logic [15:0] data, logic rv, logic [1:0] rva
  );
    @(negedge clk);
    rst = rs; r1 = a1; r2 = a2; rd = d;
    we = w; wd = data; rsv = rv; ra = rva;
    #1;
  endtask

  function automatic bit fwd(int z, logic [1:0] a);
    return we && !rst && !(z == 1 && rd == 2'd0) && rd == a;
  endfunction

  function automatic logic [15:0] exp_data(int z, logic [1:0] a);
    if (fwd(z, a)) return wd;
    if (z == 1 && a == 2'd0) return 16'h0;
    return mem[z][a];
  endfunction

  function automatic logic exp_busy(int z, logic [1:0] a);
    return bsy[z][a] && !fwd(z, a);
  endfunction

  function automatic logic [2:0] exp_pc(int z);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) n += bsy[z][i] ? 1 : 0;
    return 3'(n);
  endfunction

  // advance the model over the coming clock edge
  task automatic model_edge();
    for (int z = 0; z < 2; z++) begin
      if (rst) begin
        for (int i = 0; i < 4; i++) begin
          mem[z][i] = 16'h0;
          bsy[z][i] = 1'b0;
        end
      end else begin
        if (we && !(z == 1 && rd == 2'd0)) begin
          mem[z][rd] = wd;
          bsy[z][rd] = 1'b0;
        end
        if (rsv && !(z == 1 && ra == 2'd0)) bsy[z][ra] = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    chk("rnd z0 OutputA", 32'(bus0.OutputA), 32'(exp_data(0, r1)));
    chk("rnd z0 OutputB", 32'(bus0.OutputB), 32'(exp_data(0, r2)));
    chk("rnd z0 BusyA", 32'(bus0.BusyA), 32'(exp_busy(0, r1)));
    chk("rnd z0 BusyB", 32'(bus0.BusyB), 32'(exp_busy(0, r2)));
    chk("rnd z0 Pending", 32'(bus0.PendingCount), 32'(exp_pc(0)));
    chk("rnd z1 OutputA", 32'(bus1.OutputA), 32'(exp_data(1, r1)));
    chk("rnd z1 OutputB", 32'(bus1.OutputB), 32'(exp_data(1, r2)));
    chk("rnd z1 BusyA", 32'(bus1.BusyA), 32'(exp_busy(1, r1)));
    chk("rnd z1 BusyB", 32'(bus1.BusyB), 32'(exp_busy(1, r2)));
    chk("rnd z1 Pending", 32'(bus1.PendingCount), 32'(exp_pc(1)));
  endtask

  initial begin
    rst = 1'b1; r1 = '0; r2 = '0; rd = '0;
    we = 1'b0; wd = '0; rsv = 1'b0; ra = '0;

    //        rst r1 r2 rd we wd        rsv ra  ea        eb        ba bb pc
    tv[0]  = mk(0, 0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    tv[1]  = mk(0, 2, 0, 2, 1, 16'h1234, 0, 0, 16'h1234, 16'h0000, 0, 0, 0);
    tv[2]  = mk(0, 2, 3, 3, 1, 16'hBEEF, 0, 0, 16'h1234, 16'hBEEF, 0, 0, 0);
    tv[3]  = mk(0, 3, 2, 0, 0, 16'h0000, 1, 1, 16'hBEEF, 16'h1234, 0, 0, 0);
    tv[4]  = mk(0, 1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 1, 1);
    tv[5]  = mk(0, 1, 2, 1, 1, 16'h0011, 0, 0, 16'h0011, 16'h1234, 0, 0, 1);
    tv[6]  = mk(0, 1, 2, 0, 0, 16'h0000, 1, 2, 16'h0011, 16'h1234, 0, 0, 0);
    tv[7]  = mk(0, 2, 0, 2, 1, 16'h00AA, 1, 2, 16'h00AA, 16'h0000, 0, 0, 1);
    tv[8]  = mk(0, 2, 2, 0, 0, 16'h0000, 0, 0, 16'h00AA, 16'h00AA, 1, 1, 1);
    tv[9]  = mk(0, 0, 3, 0, 0, 16'h0000, 1, 2, 16'h0000, 16'hBEEF, 0, 0, 1);
    tv[10] = mk(0, 2, 3, 0, 0, 16'h0000, 1, 0, 16'h00AA, 16'hBEEF, 1, 0, 1);
    tv[11] = mk(0, 0, 2, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h00AA, 1, 1, 2);
    tv[12] = mk(0, 1, 3, 0, 0, 16'h0000, 1, 3, 16'h0011, 16'hBEEF, 1, 0, 3);
    tv[13] = mk(1, 1, 3, 1, 1, 16'hFFFF, 1, 2, 16'h0011, 16'hBEEF, 1, 1, 4);
    tv[14] = mk(0, 1, 2, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    tv[15] = mk(0, 3, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);

    drive(1, 0, 0, 0, 0, 16'h0, 0, 0);
    model_edge();

    for (int i = 0; i < 16; i++) begin
      drive(tv[i].rst, tv[i].r1, tv[i].r2, tv[i].rd,
            tv[i].we, tv[i].wd, tv[i].rsv, tv[i].ra);
      chk($sformatf("vec%0d OutputA", i), 32'(bus0.OutputA), 32'(tv[i].ea));
      chk($sformatf("vec%0d OutputB", i), 32'(bus0.OutputB), 32'(tv[i].eb));
      chk($sformatf("vec%0d BusyA", i), 32'(bus0.BusyA), 32'(tv[i].eba));
      chk($sformatf("vec%0d BusyB", i), 32'(bus0.BusyB), 32'(tv[i].ebb));
      chk($sformatf("vec%0d Pending", i),
          32'(bus0.PendingCount), 32'(tv[i].epc));
      model_edge();
    end

    // hardwired zero register: write and reserve of reg 0 are ignored
    drive(1, 0, 0, 0, 0, 16'h0, 0, 0);
    model_edge();
    drive(0, 0, 0, 0, 1, 16'h5555, 1, 0);
    chk("zero bypass OutputA", 32'(bus1.OutputA), 32'h0);
    chk("zero bypass BusyA", 32'(bus1.BusyA), 32'h0);
    chk("zero bypass Pending", 32'(bus1.PendingCount), 32'h0);
    model_edge();
    drive(0, 0, 1, 0, 0, 16'h0, 0, 0);
    chk("zero stored OutputA", 32'(bus1.OutputA), 32'h0);
    chk("zero stored BusyA", 32'(bus1.BusyA), 32'h0);
    chk("zero stored Pending", 32'(bus1.PendingCount), 32'h0);
    model_edge();
    drive(0, 0, 1, 1, 1, 16'h7777, 1, 1);
    chk("zero r1 bypass OutputB", 32'(bus1.OutputB), 32'h7777);
    model_edge();
    drive(0, 0, 1, 0, 0, 16'h0, 0, 0);
    chk("zero r1 OutputB", 32'(bus1.OutputB), 32'h7777);
    chk("zero r1 BusyB", 32'(bus1.BusyB), 32'h1);
    chk("zero r1 Pending", 32'(bus1.PendingCount), 32'h1);
    model_edge();

    drive(1, 0, 0, 0, 0, 16'h0, 0, 0);
    model_edge();
    for (int c = 0; c < 1500; c++) begin
      drive(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            16'($urandom), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)));
      check_model();
      model_edge();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the register data width in bits.
REQ-002 Parameter ADDR_W, default 2, SHALL set the register address width; depth SHALL be 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 0, SHALL hardwire register 0 to zero when set to 1.
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 Reset  input  1  reset, synchronous, active-high.
REQ-006 R1  input  ADDR_W  read port A address.
REQ-007 R2  input  ADDR_W  read port B address.
REQ-008 Rd  input  ADDR_W  write address.
REQ-009 RegWrite  input  1  write enable; also the writeback event that clears the busy bit.
REQ-010 WriteData  input  DATA_W  write data.
REQ-011 Reserve  input  1  mark ReserveAddr as having a write outstanding.
REQ-012 ReserveAddr  input  ADDR_W  register to reserve.
REQ-013 OutputA  output  DATA_W  read data, port A.
REQ-014 OutputB  output  DATA_W  read data, port B.
REQ-015 BusyA  output  1  R1 has an outstanding reservation.
REQ-016 BusyB  output  1  R2 has an outstanding reservation.
REQ-017 PendingCount  output  ADDR_W+1  number of busy registers.

Function
REQ-018 A write SHALL update register Rd at the rising CLK edge when RegWrite=1 and Reset=0.
REQ-019 When ZERO_REG=1, writes to address 0 SHALL be discarded, and reads of address 0 SHALL return 0.
REQ-020 Reads SHALL be combinational, reacting to R1, R2, every register value, and the bypass inputs, with zero-cycle latency.
REQ-021 Bypass: when RegWrite=1, Reset=0 and Rd==R1, OutputA SHALL equal WriteData in the same cycle, and port B SHALL behave identically for R2.
REQ-022 Bypass SHALL NOT apply to address 0 when ZERO_REG=1.
REQ-023 The busy bit of ReserveAddr SHALL set at the edge when Reserve=1.
REQ-024 The busy bit of Rd SHALL clear at the edge when RegWrite=1.
REQ-025 Reserve and RegWrite to the same address in the same cycle: data SHALL be written and the busy bit SHALL end set (reserve wins).
REQ-026 Reserve and RegWrite to different addresses in the same cycle: both actions SHALL take effect.
REQ-027 Reserve of an already-busy register SHALL leave it busy, with no count change.
REQ-028 RegWrite to a non-busy register SHALL write data and leave the busy bit 0.
REQ-029 BusyA SHALL be busy[R1] AND NOT (RegWrite AND Rd==R1), so that writeback clears the hazard in the same cycle; BusyB SHALL be defined likewise for R2.
REQ-030 When ZERO_REG=1, register 0 SHALL never be busy, and Reserve to address 0 SHALL be ignored.
REQ-031 PendingCount SHALL be the registered population count of the busy bits, updated at the same edge as those bits, with range 0..2**ADDR_W and no wrap.

Reset
REQ-032 On a rising edge with Reset=1, all registers SHALL become 0, all busy bits SHALL become 0, and PendingCount SHALL become 0.
REQ-033 Reset SHALL dominate RegWrite and Reserve in the same cycle, so no write or reservation takes effect.
REQ-034 While Reset=1, bypass and busy-clear forwarding SHALL be suppressed, and the outputs SHALL reflect stored state only.
REQ-035 After the reset edge, OutputA=OutputB=0, BusyA=BusyB=0 and PendingCount=0.

Structure
REQ-036 Package regfile_pkg SHALL hold the default DATA_W and ADDR_W constants and a function for the busy-bit population count.
REQ-037 One sub-module, regfile_read_port (address mux, bypass and busy forwarding), SHALL be instantiated once per read port.
REQ-038 There SHALL be no latches and no default data values other than 0.

Verification (DATA_W=16, ADDR_W=2 unless noted)
REQ-039 Reset, then write 0x1234 to reg 2, then R1=2 next cycle -> OutputA=0x1234 and BusyA=0.
REQ-040 RegWrite=1, Rd=3, WriteData=0xBEEF, R2=3 in the same cycle -> OutputB=0xBEEF combinationally (bypass), and stored value 0xBEEF afterwards.
REQ-041 Reserve reg 1 -> BusyA=1 for R1=1 and PendingCount=1; then RegWrite Rd=1 -> BusyA=0 in that cycle and PendingCount=0 after the edge.
REQ-042 Reserve=1, ReserveAddr=2 together with RegWrite=1, Rd=2, data 0x00AA -> reg 2=0x00AA, busy[2]=1, PendingCount unchanged at 1.
REQ-043 Reserve all four registers, then assert Reset with RegWrite=1 -> all registers 0, PendingCount=0, and no write landed.
REQ-044 ZERO_REG=1: write 0x5555 to reg 0 and Reserve reg 0 -> OutputA=0 for R1=0, BusyA=0, PendingCount=0.
